// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter: round-robin arbiter sharing one data-memory port among N_REQ cores.
//
// Purpose: grants at most one core request per cycle to the shared memory port and
// forwards that core's fields. An in-order tag FIFO records the owner of each
// outstanding access, and each memory response is routed back to its owner.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_req/i_we/i_addr/    per-requester request, write enable, address,
//   i_wstrb/i_wdata       byte strobes and write data (requester k in slice k)
//   o_gnt                 one-hot grant, combinational with the accepted request
//   o_valid, o_rdata      one-hot response strobe to the owner, broadcast data
//   o_mem_*               granted access towards the shared memory
//   i_mem_gnt             memory can accept an access this cycle
//   i_mem_valid/rdata     in-order memory response
//   o_err                 sticky: a response arrived with no outstanding tag
module dmem_rr_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ-1:0]      i_we,
  input  logic [32*N_REQ-1:0]   i_addr,
  input  logic [4*N_REQ-1:0]    i_wstrb,
  input  logic [32*N_REQ-1:0]   i_wdata,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [N_REQ-1:0]      o_valid,
  output logic [31:0]           o_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [31:0]           o_mem_addr,
  output logic [3:0]            o_mem_wstrb,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_valid,
  input  logic [31:0]           i_mem_rdata,
  output logic                  o_err
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned PtrW = $clog2(MAX_OUTST);
  localparam int unsigned CntW = PtrW + 1;

  logic [IdxW-1:0] last_q, last_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q;
  logic [IdxW-1:0] tag_q [MAX_OUTST];

  logic             fifo_full_eff;
  logic [N_REQ-1:0] elig;
  logic             push, pop;
  logic [IdxW-1:0]  winner, sel, head;
  int               best_rank;

  // A same-cycle pop frees a slot, so a full FIFO can still accept when a response lands.
  assign fifo_full_eff = (count_q == CntW'(MAX_OUTST)) && !i_mem_valid;
  assign elig          = i_req & {N_REQ{i_mem_gnt && !fifo_full_eff && !i_rst}};

  // Rank each requester by its distance after last_q; the lowest rank that is eligible wins.
  always_comb begin
    push      = 1'b0;
    winner    = '0;
    best_rank = int'(N_REQ);
    for (int k = 0; k < int'(N_REQ); k++) begin
      int rank;
      rank = (k + int'(N_REQ) - int'(last_q) - 1) % int'(N_REQ);
      if (elig[k] && rank < best_rank) begin
        best_rank = rank;
        winner    = IdxW'(k);
        push      = 1'b1;
      end
    end
  end

  // Without a grant the memory fields show requester 0 (don't care, o_mem_req is low).
  assign sel    = push ? winner : '0;
  assign last_d = push ? winner : last_q;

  always_comb begin
    o_gnt       = '0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wstrb = '0;
    o_mem_wdata = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (sel == IdxW'(k)) begin
        o_gnt[k]    = push;
        o_mem_we    = i_we[k];
        o_mem_addr  = i_addr[32*k +: 32];
        o_mem_wstrb = i_wstrb[4*k +: 4];
        o_mem_wdata = i_wdata[32*k +: 32];
      end
    end
  end

  assign o_mem_req = push;

  // Response path.
  assign pop  = i_mem_valid && (count_q != '0) && !i_rst;
  assign head = tag_q[rd_ptr_q];

  always_comb begin
    o_valid = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      o_valid[k] = pop && (head == IdxW'(k));
    end
  end

  assign o_rdata = i_rst ? '0 : i_mem_rdata;
  assign o_err   = err_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      last_q  <= last_d;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      // Orphan response: nothing outstanding to route it to.
      if (i_mem_valid && count_q == '0) begin
        err_q <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset; entries are only read below count_q.
  always_ff @(posedge i_clk) begin
    if (push) begin
      tag_q[wr_ptr_q] <= winner;
    end
  end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Self-checking bench for dmem_rr_arbiter (N_REQ=2, MAX_OUTST=4). A reference
// round-robin model predicts grants; each expected grant pushes its owner and
// response data onto a scoreboard queue that is popped when a response is driven.
module tb_dmem_rr_arbiter;
  localparam int unsigned NReq     = 2;
  localparam int unsigned MaxOutst = 4;

  logic             clk, rst;
  logic [NReq-1:0]  req, we, gnt, valid;
  logic [63:0]      addr, wdata;
  logic [7:0]       wstrb;
  logic [31:0]      rdata, mem_addr, mem_wdata, mem_rdata;
  logic             mem_req, mem_we, mem_gnt, mem_valid, err;
  logic [3:0]       mem_wstrb;

  dmem_rr_arbiter #(.N_REQ(NReq), .MAX_OUTST(MaxOutst)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wstrb(wstrb),
    .i_wdata(wdata), .o_gnt(gnt), .o_valid(valid), .o_rdata(rdata), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wstrb(mem_wstrb),
    .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt), .i_mem_valid(mem_valid),
    .i_mem_rdata(mem_rdata), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int owner; logic [31:0] data;} exp_t;
  exp_t            sb_q[$];
  int              last_m;
  logic            err_m;
  int              exp_win;
  logic [NReq-1:0] exp_gnt, exp_valid;
  logic [31:0]     exp_rdata;
  int              n_checks, n_fail;

  // Drive one cycle of stimulus and compute the model's expectations for it.
  task automatic drive(input logic [NReq-1:0] r, input logic mg, input logic mv);
    logic full;
    req = r; mem_gnt = mg; mem_valid = mv;
    exp_valid = '0;
    if (mv && sb_q.size() > 0) begin
      mem_rdata = sb_q[0].data;
      exp_valid = NReq'(1) << sb_q[0].owner;
    end else begin
      mem_rdata = 32'h0BAD_F00D;
    end
    exp_rdata = mem_rdata;
    full = (sb_q.size() == MaxOutst) && !mv;
    exp_win = -1;
    for (int i = 1; i <= int'(NReq); i++) begin
      int k;
      k = (last_m + i) % int'(NReq);
      if (exp_win < 0 && r[k] && mg && !full) exp_win = k;
    end
    exp_gnt = (exp_win >= 0) ? (NReq'(1) << exp_win) : '0;
  endtask

  // Clock edge: retire the response and record the granted access in the scoreboard.
  task automatic advance();
    @(posedge clk);
    if (mem_valid) begin
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      else err_m = 1'b1;
    end
    if (exp_win >= 0) begin
      last_m = exp_win;
      sb_q.push_back('{owner: exp_win, data: wdata[exp_win*32 +: 32]});
    end
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; we = '0; mem_gnt = 1'b1; mem_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    addr = {32'h0000_0200, 32'h0000_0100};
    wdata = {32'hCAFE_0001, 32'hDEAD_BEEF};
    wstrb = 8'hFF;
    req = 2'b11; mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
    #3;
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++; if (valid !== 2'b00 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_resp: got valid %b rdata %h want 00/0", valid, rdata);
    end
    @(posedge clk); #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    idle_inputs();
    rst = 1'b0;
    last_m = 0; err_m = 1'b0; sb_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    drive(2'b01, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++; if (gnt !== 2'b01 || mem_req !== 1'b1 || mem_addr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL single_gnt: got gnt %b req %b addr %h want 01/1/00000100", gnt, mem_req, mem_addr);
    end
    advance();
    for (int c = 0; c < 2; c++) begin drive(2'b00, 1'b1, 1'b0); advance(); end
    drive(2'b00, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++; if (valid !== 2'b01 || rdata !== 32'hDEAD_BEEF || exp_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_resp: got valid %b rdata %h want 01/deadbeef", valid, rdata);
    end
    advance();
  endtask

  task automatic test_fairness();
    logic [NReq-1:0] want [4];
    want = '{2'b10, 2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++; if (gnt !== exp_gnt || gnt !== want[i]) begin
        n_fail++; $display("FAIL fair_gnt[%0d]: got %b want %b", i, gnt, want[i]);
      end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 1'b1, 1'b1);
      @(negedge clk);
      n_checks++; if (valid !== exp_valid || rdata !== exp_rdata) begin
        n_fail++; $display("FAIL fair_resp[%0d]: got %b/%h want %b/%h", i, valid, rdata, exp_valid, exp_rdata);
      end
      advance();
    end
  endtask

  task automatic test_ordering();
    logic [NReq-1:0] rq [3];
    rq = '{2'b10, 2'b01, 2'b10};
    we = 2'b10; wstrb = 8'h3F; wdata = {32'hA0A0_0001, 32'hB0B0_0002};
    for (int i = 0; i < 3; i++) begin
      drive(rq[i], 1'b1, 1'b0);
      @(negedge clk);
      n_checks++; if (gnt !== exp_gnt || mem_addr !== addr[exp_win*32 +: 32]
                      || mem_we !== we[exp_win] || mem_wstrb !== wstrb[exp_win*4 +: 4]
                      || mem_wdata !== wdata[exp_win*32 +: 32]) begin
        n_fail++; $display("FAIL order_gnt[%0d]: got %b we%b %h %h %h want %b", i, gnt, mem_we,
                           mem_addr, mem_wstrb, mem_wdata, exp_gnt);
      end
      advance();
      if (i == 0) wdata[63:32] = 32'hC0C0_0003;
    end
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b1, 1'b1);
      @(negedge clk);
      n_checks++; if (valid !== exp_valid || rdata !== exp_rdata) begin
        n_fail++; $display("FAIL order_resp[%0d]: got %b/%h want %b/%h", i, valid, rdata, exp_valid, exp_rdata);
      end
      advance();
    end
    we = '0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 6; i++) begin
      // cycles 0-3 fill, 4 waits, 5 pops and grants together
      drive(2'b01, 1'b1, i == 5);
      @(negedge clk);
      n_checks++; if (gnt !== exp_gnt || mem_req !== (exp_win >= 0) || valid !== exp_valid) begin
        n_fail++; $display("FAIL full[%0d]: got gnt %b req %b valid %b want %b/%b", i, gnt, mem_req,
                           valid, exp_gnt, exp_valid);
      end
      advance();
    end
    drive(2'b01, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL full_still: got %b want 00", gnt); end
    advance();
    while (sb_q.size() > 0) begin
      drive(2'b00, 1'b1, 1'b1);
      @(negedge clk);
      n_checks++; if (valid !== exp_valid || rdata !== exp_rdata) begin
        n_fail++; $display("FAIL full_drain: got %b/%h want %b/%h", valid, rdata, exp_valid, exp_rdata);
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, i == 3, 1'b0);
      @(negedge clk);
      n_checks++; if (gnt !== exp_gnt || mem_req !== (i == 3)) begin
        n_fail++; $display("FAIL bp[%0d]: got gnt %b req %b want %b", i, gnt, mem_req, exp_gnt);
      end
      advance();
    end
    drive(2'b00, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++; if (valid !== exp_valid || valid !== 2'b01) begin
      n_fail++; $display("FAIL bp_resp: got %b want 01", valid);
    end
    advance();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 2; i++) begin drive(2'b11, 1'b1, 1'b0); advance(); end
    req = 2'b01; mem_valid = 1'b1; mem_rdata = 32'h7777_0000;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (gnt !== 2'b00 || mem_req !== 1'b0 || valid !== 2'b00 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_out: got %b %b %b %h want all 0", gnt, mem_req, valid, rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete(); last_m = 0; err_m = 1'b0;
    drive(2'b00, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++; if (valid !== 2'b00) begin n_fail++; $display("FAIL mid_orphan_valid: got %b want 00", valid); end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++; if (err !== err_m || err !== 1'b1) begin
        n_fail++; $display("FAIL mid_err[%0d]: got %b want 1", i, err);
      end
      advance();
    end
    rst = 1'b1; #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
    @(posedge clk); #1;
    rst = 1'b0; err_m = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    test_reset();
    test_single();
    test_fairness();
    test_ordering();
    test_full();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
